// File: rtl/version_string_reader_if.sv
// Bus-initiator and byte-stream signals of the version string reader.
// master: the reader itself. slave: the bus/consumer side (bench or fabric).
interface version_string_reader_if #(
  parameter int address_width = 15,
  parameter int data_width    = 16
);
  logic                     bus_req_o;
  logic                     bus_gnt_i;
  logic [address_width-1:0] address_o;
  logic [data_width-1:0]    data_o;
  logic                     rd_wr_o;
  logic [data_width-1:0]    data_i;
  logic [7:0]               tx_data_o;
  logic                     tx_valid_o;
  logic                     tx_ready_i;

  modport master (
    output bus_req_o, address_o, data_o, rd_wr_o, tx_data_o, tx_valid_o,
    input  bus_gnt_i, data_i, tx_ready_i
  );

  modport slave (
    input  bus_req_o, address_o, data_o, rd_wr_o, tx_data_o, tx_valid_o,
    output bus_gnt_i, data_i, tx_ready_i
  );
endinterface

// File: rtl/version_string_reader.sv
// Fetches the packed firmware version string word by word over the system
// bus and streams its bytes (most significant byte of each word first) on a
// valid/ready byte interface.
// Optional: define VERSION_READER_NEWLINE_EN to append 0x0D 0x0A after the
// string.
//
// state | meaning
// IDLE  | waiting for start_i, bus untouched
// REQ   | requesting the bus for word k
// WAIT  | granted, counting read latency before sampling data_i
// SEND  | presenting bytes of the captured word
// NL    | presenting CR then LF (newline build only)
// DONE  | one-cycle completion pulse
module version_string_reader #(
  parameter int BaseAddress   = 0,
  parameter int NumCharacters = 44,
  parameter int CharsPerWord  = 2,
  parameter int ReadLatency   = 1,
  parameter int address_width = 15,
  parameter int data_width    = 16
) (
  input  logic clk_i,
  input  logic reset_i,
  input  logic start_i,
  output logic busy_o,
  output logic done_o,
  version_string_reader_if.master bus
);

  localparam int NumWords = NumCharacters / CharsPerWord;
  localparam int WordIdxW = (NumWords > 1) ? $clog2(NumWords) : 1;
  localparam int ByteIdxW = (CharsPerWord > 1) ? $clog2(CharsPerWord) : 1;
  localparam int LatW     = (ReadLatency > 1) ? $clog2(ReadLatency) : 1;

  localparam logic [WordIdxW-1:0] LastWord = WordIdxW'(NumWords - 1);
  localparam logic [ByteIdxW-1:0] LastByte = ByteIdxW'(CharsPerWord - 1);
  localparam logic [LatW-1:0]     LatLoad  = (ReadLatency > 0) ? LatW'(ReadLatency - 1) : '0;

`ifdef VERSION_READER_NEWLINE_EN
  typedef enum logic [2:0] {IDLE, REQ, WAIT, SEND, NL, DONE} state_t;
`else
  typedef enum logic [2:0] {IDLE, REQ, WAIT, SEND, DONE} state_t;
`endif

  state_t state_q, state_d;

  logic [WordIdxW-1:0]      word_idx_q;
  logic [ByteIdxW-1:0]      byte_idx_q;
  logic [LatW-1:0]          lat_q;
  logic [data_width-1:0]    word_q;
  logic [7:0]               cur_byte;
  logic [address_width-1:0] cur_addr;

  logic word_clr, word_inc, byte_clr, byte_inc, lat_load, lat_dec, capture;
  logic req, valid;
  logic [7:0] tx_byte;
  logic [address_width-1:0] addr;

  assign cur_addr = address_width'(BaseAddress) + address_width'(word_idx_q);

  // Pick the byte of the captured word selected by byte_idx_q, MSB byte first.
  always_comb begin
    cur_byte = '0;
    for (int j = 0; j < CharsPerWord; j++) begin
      if (byte_idx_q == ByteIdxW'(j)) cur_byte = word_q[8*(CharsPerWord-1-j) +: 8];
    end
  end

  // State register; a low reset_i aborts any operation in progress.
  always_ff @(posedge clk_i) begin
    if (!reset_i) state_q <= IDLE;
    else          state_q <= state_d;
  end

  // Word/byte indices, latency down-counter and captured word.
  always_ff @(posedge clk_i) begin
    if (!reset_i) begin
      word_idx_q <= '0;
      byte_idx_q <= '0;
      lat_q      <= '0;
      word_q     <= '0;
    end else begin
      if (word_clr)      word_idx_q <= '0;
      else if (word_inc) word_idx_q <= word_idx_q + WordIdxW'(1);
      if (byte_clr)      byte_idx_q <= '0;
      else if (byte_inc) byte_idx_q <= byte_idx_q + ByteIdxW'(1);
      if (lat_load)      lat_q <= LatLoad;
      else if (lat_dec)  lat_q <= lat_q - LatW'(1);
      if (capture)       word_q <= bus.data_i;
    end
  end

  // Next-state decode and Moore outputs.
  always_comb begin
    state_d  = state_q;
    word_clr = 1'b0;
    word_inc = 1'b0;
    byte_clr = 1'b0;
    byte_inc = 1'b0;
    lat_load = 1'b0;
    lat_dec  = 1'b0;
    capture  = 1'b0;
    req      = 1'b0;
    addr     = '0;
    valid    = 1'b0;
    tx_byte  = '0;
    busy_o   = (state_q != IDLE);
    done_o   = 1'b0;
    unique case (state_q)
      IDLE: begin
        if (start_i) begin
          state_d  = REQ;
          word_clr = 1'b1;
          byte_clr = 1'b1;
        end
      end
      REQ: begin
        req  = 1'b1;
        addr = cur_addr;
        if (bus.bus_gnt_i) begin
          if (ReadLatency == 0) begin
            capture  = 1'b1;
            byte_clr = 1'b1;
            state_d  = SEND;
          end else begin
            lat_load = 1'b1;
            state_d  = WAIT;
          end
        end
      end
      WAIT: begin
        req  = 1'b1;
        addr = cur_addr;
        if (!bus.bus_gnt_i) begin
          state_d = REQ;
        end else if (lat_q == '0) begin
          capture  = 1'b1;
          byte_clr = 1'b1;
          state_d  = SEND;
        end else begin
          lat_dec = 1'b1;
        end
      end
      SEND: begin
        valid   = 1'b1;
        tx_byte = cur_byte;
        if (bus.tx_ready_i) begin
          if (byte_idx_q == LastByte) begin
            byte_clr = 1'b1;
            if (word_idx_q == LastWord) begin
`ifdef VERSION_READER_NEWLINE_EN
              state_d = NL;
`else
              state_d = DONE;
`endif
            end else begin
              word_inc = 1'b1;
              state_d  = REQ;
            end
          end else begin
            byte_inc = 1'b1;
          end
        end
      end
`ifdef VERSION_READER_NEWLINE_EN
      NL: begin
        valid   = 1'b1;
        tx_byte = (byte_idx_q == '0) ? 8'h0D : 8'h0A;
        if (bus.tx_ready_i) begin
          if (byte_idx_q == '0) byte_inc = 1'b1;
          else                  state_d  = DONE;
        end
      end
`endif
      DONE: begin
        done_o  = 1'b1;
        state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase
  end

  assign bus.bus_req_o  = req;
  assign bus.address_o  = addr;
  assign bus.data_o     = '0;
  assign bus.rd_wr_o    = 1'b0;
  assign bus.tx_valid_o = valid;
  assign bus.tx_data_o  = tx_byte;

endmodule

// File: tb/tb_version_string_reader.sv
// Bench for version_string_reader: 2-word string at 0x10, 1-cycle bus latency.
module tb_version_string_reader;
  localparam int Base = 16'h10;
  localparam int NChr = 4;
  localparam int Cpw  = 2;
  localparam int Nw   = NChr / Cpw;
  localparam int Aw   = 15;
  localparam int Dw   = 16;

  logic clk = 1'b0;
  logic reset_i = 1'b0;
  logic start_i = 1'b0;
  logic busy_o, done_o;

  version_string_reader_if #(.address_width(Aw), .data_width(Dw)) bus_if ();

  version_string_reader #(
    .BaseAddress(Base), .NumCharacters(NChr), .CharsPerWord(Cpw),
    .ReadLatency(1), .address_width(Aw), .data_width(Dw)
  ) u_dut (
    .clk_i(clk), .reset_i(reset_i), .start_i(start_i),
    .busy_o(busy_o), .done_o(done_o), .bus(bus_if)
  );

  always #5 clk = ~clk;

  int n_assert = 0;
  int n_fail   = 0;

  logic [Dw-1:0] mem [Nw];
  logic [7:0]    got [$];
  logic [Aw-1:0] rd_addrs [$];
  int            done_cnt = 0;
  logic          prev_req = 1'b0;
  logic          prev_stall = 1'b0;
  logic [7:0]    prev_byte = '0;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_assert++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  // Bus slave: one-cycle read latency, garbage whenever not granted.
  always @(posedge clk) begin
    if (bus_if.bus_req_o && bus_if.bus_gnt_i) begin
      if (int'(bus_if.address_o) >= Base && int'(bus_if.address_o) < Base + Nw)
        bus_if.data_i <= mem[int'(bus_if.address_o) - Base];
      else
        bus_if.data_i <= 16'hDEAD;
    end else begin
      bus_if.data_i <= Dw'($urandom);
    end
  end

  // Monitor: accepted bytes, read starts, done pulses, stall stability.
  always @(negedge clk) begin
    if (reset_i && bus_if.tx_valid_o && bus_if.tx_ready_i) got.push_back(bus_if.tx_data_o);
    if (done_o) done_cnt++;
    if (bus_if.bus_req_o && !prev_req) rd_addrs.push_back(bus_if.address_o);
    if (prev_stall && reset_i) begin
      chk("stall_valid", bus_if.tx_valid_o, 1);
      chk("stall_data", bus_if.tx_data_o, prev_byte);
    end
    prev_stall = bus_if.tx_valid_o && !bus_if.tx_ready_i;
    prev_byte  = bus_if.tx_data_o;
    prev_req   = bus_if.bus_req_o;
  end

  function automatic void expected_bytes(output logic [7:0] q [$]);
    q = {};
    for (int k = 0; k < Nw; k++)
      for (int j = 0; j < Cpw; j++)
        q.push_back(8'(mem[k] >> (8 * (Cpw - 1 - j))));
`ifdef VERSION_READER_NEWLINE_EN
    q.push_back(8'h0D);
    q.push_back(8'h0A);
`endif
  endfunction

  task automatic clear_sb();
    got.delete();
    rd_addrs.delete();
    done_cnt = 0;
  endtask

  task automatic start_pulse();
    start_i = 1'b1;
    @(posedge clk); #1;
    start_i = 1'b0;
  endtask

  task automatic wait_done(input int rnd, input int budget);
    int n = 0;
    while (done_cnt == 0 && n < budget) begin
      if (rnd != 0) begin
        bus_if.tx_ready_i = ($urandom_range(0, 9) < 6);
        bus_if.bus_gnt_i  = ($urandom_range(0, 3) != 0);
      end
      @(posedge clk); #1;
      n++;
    end
    chk("done_seen", done_cnt != 0, 1);
    chk("busy_after_done", busy_o, 0);
    chk("done_one_cycle", done_o, 0);
  endtask

  task automatic check_stream(input string tag);
    logic [7:0] exp_q [$];
    expected_bytes(exp_q);
    chk({tag, "_nbytes"}, got.size(), exp_q.size());
    for (int i = 0; i < exp_q.size() && i < got.size(); i++)
      chk({tag, "_byte"}, got[i], exp_q[i]);
    chk({tag, "_nreads"}, rd_addrs.size(), Nw);
    for (int k = 0; k < Nw && k < rd_addrs.size(); k++)
      chk({tag, "_addr"}, rd_addrs[k], Base + k);
    chk({tag, "_done_cnt"}, done_cnt, 1);
    chk({tag, "_rd_wr"}, bus_if.rd_wr_o, 0);
    chk({tag, "_data_o"}, bus_if.data_o, 0);
  endtask

  task automatic check_idle(input string tag);
    chk({tag, "_req"}, bus_if.bus_req_o, 0);
    chk({tag, "_addr"}, bus_if.address_o, 0);
    chk({tag, "_data_o"}, bus_if.data_o, 0);
    chk({tag, "_rd_wr"}, bus_if.rd_wr_o, 0);
    chk({tag, "_tx_data"}, bus_if.tx_data_o, 0);
    chk({tag, "_tx_valid"}, bus_if.tx_valid_o, 0);
    chk({tag, "_busy"}, busy_o, 0);
    chk({tag, "_done"}, done_o, 0);
  endtask

  initial begin
    int n;
    bus_if.bus_gnt_i  = 1'b0;
    bus_if.tx_ready_i = 1'b0;
    mem[0] = 16'h4142;
    mem[1] = 16'h4344;

    // Reset values, then idle after release.
    repeat (3) @(posedge clk);
    #1;
    check_idle("reset");
    reset_i = 1'b1;
    @(posedge clk); #1;
    check_idle("idle");

    // Basic stream with first-byte latency.
    clear_sb();
    bus_if.bus_gnt_i  = 1'b1;
    bus_if.tx_ready_i = 1'b1;
    start_pulse();
    chk("lat_c1_busy", busy_o, 1);
    chk("lat_c1_req", bus_if.bus_req_o, 1);
    chk("lat_c1_addr", bus_if.address_o, Base);
    chk("lat_c1_valid", bus_if.tx_valid_o, 0);
    @(posedge clk); #1;
    chk("lat_c2_valid", bus_if.tx_valid_o, 0);
    @(posedge clk); #1;
    chk("lat_c3_valid", bus_if.tx_valid_o, 1);
    chk("lat_c3_data", bus_if.tx_data_o, 8'h41);
    wait_done(0, 50);
    check_stream("basic");

    // Backpressure while 0x42 is presented.
    clear_sb();
    start_pulse();
    n = 0;
    while (!(bus_if.tx_valid_o && bus_if.tx_data_o == 8'h42) && n < 20) begin
      @(posedge clk); #1;
      n++;
    end
    chk("bp_reached", bus_if.tx_data_o, 8'h42);
    bus_if.tx_ready_i = 1'b0;
    for (int i = 0; i < 5; i++) begin
      chk("bp_data", bus_if.tx_data_o, 8'h42);
      chk("bp_no_req", bus_if.bus_req_o, 0);
      @(posedge clk); #1;
    end
    chk("bp_hold_end", bus_if.tx_data_o, 8'h42);
    bus_if.tx_ready_i = 1'b1;
    wait_done(0, 50);
    check_stream("bp");

    // Grant withheld 4 cycles, then lost during WAIT of word 1.
    clear_sb();
    bus_if.bus_gnt_i = 1'b0;
    start_pulse();
    for (int i = 0; i < 4; i++) begin
      chk("gnt_wait_req", bus_if.bus_req_o, 1);
      chk("gnt_wait_valid", bus_if.tx_valid_o, 0);
      @(posedge clk); #1;
    end
    bus_if.bus_gnt_i = 1'b1;
    n = 0;
    while (!(bus_if.bus_req_o && bus_if.address_o == Aw'(Base + 1)) && n < 30) begin
      @(posedge clk); #1;
      n++;
    end
    chk("gnt_w1_addr", bus_if.address_o, Base + 1);
    @(posedge clk); #1;
    bus_if.bus_gnt_i = 1'b0;
    @(posedge clk); #1;
    chk("gnt_reissue_req", bus_if.bus_req_o, 1);
    chk("gnt_reissue_addr", bus_if.address_o, Base + 1);
    chk("gnt_reissue_valid", bus_if.tx_valid_o, 0);
    bus_if.bus_gnt_i = 1'b1;
    wait_done(0, 50);
    check_stream("gnt");

    // Start pulse while busy is ignored.
    clear_sb();
    start_pulse();
    @(posedge clk); #1;
    @(posedge clk); #1;
    start_pulse();
    wait_done(0, 50);
    repeat (5) @(posedge clk);
    #1;
    chk("sbusy_idle", busy_o, 0);
    check_stream("sbusy");

    // Reset after byte 0x42 is accepted.
    clear_sb();
    start_pulse();
    n = 0;
    while (got.size() < 2 && n < 20) begin
      @(posedge clk); #1;
      n++;
    end
    chk("rst_two_bytes", got.size(), 2);
    reset_i = 1'b0;
    @(posedge clk); #1;
    check_idle("rst_mid");
    reset_i = 1'b1;
    repeat (3) @(posedge clk);
    #1;
    chk("rst_stays_idle", busy_o, 0);
    chk("rst_no_done", done_cnt, 0);
    clear_sb();
    start_pulse();
    wait_done(0, 50);
    check_stream("rst_restart");

    // Random string contents with random grant/ready.
    for (int r = 0; r < 6; r++) begin
      for (int k = 0; k < Nw; k++) mem[k] = Dw'($urandom);
      clear_sb();
      start_pulse();
      wait_done(1, 400);
      bus_if.tx_ready_i = 1'b1;
      bus_if.bus_gnt_i  = 1'b1;
      check_stream("rand");
    end

    $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
    $finish;
  end
endmodule
